// File: rtl/azadi_spi_slave.sv
// Mode-0, MSB-first SPI responder oversampled by clk_i.
// Pad inputs are synchronized; the holding register feeds a shift-out register on each word boundary.
module azadi_spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sclk_i,
    input  logic                  ss_ni,
    input  logic                  sd_i,
    output logic                  sd_o,
    output logic                  sd_oe,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    output logic                  tx_underrun_o,
    output logic                  busy_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, sd_sync;
    logic                   sclk_d;
    logic                   sclk_s, ss_s, sd_s;
    logic                   rise, fall;

    logic                   hold_full;
    logic [DATA_WIDTH-1:0]  hold_data;
    logic                   tx_load;
    logic                   consume;

    logic [DATA_WIDTH-1:0]  shift_out;
    logic [DATA_WIDTH-2:0]  shift_in;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   reload_pending;
    logic                   rx_vld_p1;

    logic                   word_load;
    logic                   shift_en;
    logic                   sample_en;
    logic                   word_done;
    logic                   cnt_clr;
    logic                   reload_clr;

    // Stage p0: pad synchronizers and SCLK edge detect
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            sd_sync   <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_ni};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sd_i};
            sclk_d    <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign sd_s   = sd_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;
    assign fall   = ~sclk_s & sclk_d;

    assign tx_ready_o = ~hold_full;
    assign tx_load    = tx_valid_i & tx_ready_o;
    assign consume    = word_load & hold_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_full <= 1'b0;
        end else if (tx_load) begin
            hold_full <= 1'b1;
        end else if (consume) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tx_load) begin
            hold_data <= tx_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A deselect seen together with the final SCLK fall wins, so the trailing fall never reloads.
    always_comb begin
        state_d    = state_q;
        word_load  = 1'b0;
        shift_en   = 1'b0;
        sample_en  = 1'b0;
        word_done  = 1'b0;
        cnt_clr    = 1'b0;
        reload_clr = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr    = 1'b1;
                reload_clr = 1'b1;
                if (!ss_s) begin
                    word_load = 1'b1;
                    state_d   = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ss_s) begin
                    state_d    = IDLE;
                    cnt_clr    = 1'b1;
                    reload_clr = 1'b1;
                end else begin
                    if (rise) begin
                        sample_en = 1'b1;
                        word_done = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
                    end
                    if (fall) begin
                        if (reload_pending) begin
                            word_load  = 1'b1;
                            reload_clr = 1'b1;
                        end else begin
                            shift_en = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: bit counter, shift registers and word boundary bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt        <= '0;
            reload_pending <= 1'b0;
        end else begin
            if (cnt_clr || word_done) begin
                bit_cnt <= '0;
            end else if (sample_en) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (reload_clr) begin
                reload_pending <= 1'b0;
            end else if (word_done) begin
                reload_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (word_load) begin
            shift_out <= hold_full ? hold_data : '0;
        end else if (shift_en) begin
            shift_out <= {shift_out[DATA_WIDTH-2:0], 1'b0};
        end
        if (sample_en) begin
            shift_in <= {shift_in[DATA_WIDTH-3:0], sd_s};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_data_o     <= '0;
            rx_vld_p1     <= 1'b0;
            rx_valid_o    <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            if (word_done) begin
                rx_data_o <= {shift_in, sd_s};
            end
            rx_vld_p1     <= word_done;
            rx_valid_o    <= rx_vld_p1;
            tx_underrun_o <= word_load & ~hold_full;
        end
    end

    // Stage p2: registered MISO so the MSB appears one clock after the load or shift
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sd_o <= 1'b0;
        end else begin
            sd_o <= (state_q == ACTIVE) ? shift_out[DATA_WIDTH-1] : 1'b0;
        end
    end

    assign sd_oe  = (state_q == ACTIVE);
    assign busy_o = (state_q == ACTIVE);

endmodule

// File: tb/tb_azadi_spi_slave.sv
// Directed bench for azadi_spi_slave: table of single-word frames plus
// hand-written back-to-back, abort and mid-frame reset sequences.
module tb_azadi_spi_slave;

    logic       clk;
    logic       rst_ni;
    logic       sclk;
    logic       ss_n;
    logic       sd;
    logic       sd_o;
    logic       sd_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       tx_underrun_o;
    logic       busy_o;

    int checks = 0;
    int errors = 0;
    int rx_total = 0;
    int ur_total = 0;
    logic [7:0] rx_log [0:15];

    azadi_spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .sclk_i       (sclk),
        .ss_ni        (ss_n),
        .sd_i         (sd),
        .sd_o         (sd_o),
        .sd_oe        (sd_oe),
        .tx_data_i    (tx_data),
        .tx_valid_i   (tx_valid),
        .tx_ready_o   (tx_ready_o),
        .rx_data_o    (rx_data_o),
        .rx_valid_o   (rx_valid_o),
        .tx_underrun_o(tx_underrun_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid_o) begin
            rx_log[rx_total % 16] = rx_data_o;
            rx_total = rx_total + 1;
        end
        if (tx_underrun_o) begin
            ur_total = ur_total + 1;
        end
    end

    typedef struct {
        logic       load;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_rx;
        int         exp_ur;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_tx(input logic [7:0] d);
        int n;
        n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", {31'd0, tx_ready_o}, 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_fall", {31'd0, tx_ready_o}, 32'd0);
    endtask

    task automatic start_frame();
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Master drives MOSI in the low phase, samples MISO on the rising edge.
    task automatic spi_bit(input logic b, input bit end_frame, output logic m);
        sd = b;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        m = sd_o;
        repeat (8) @(negedge clk);
        sclk = 1'b0;
        if (end_frame) ss_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic spi_word(input logic [7:0] mosi, input bit end_frame, output logic [7:0] miso);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(mosi[i], end_frame && (i == 0), m);
            miso[i] = m;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sd_o"}, {31'd0, sd_o}, 32'd0);
        check({tag, "_sd_oe"}, {31'd0, sd_oe}, 32'd0);
        check({tag, "_tx_ready"}, {31'd0, tx_ready_o}, 32'd1);
        check({tag, "_rx_data"}, {24'd0, rx_data_o}, 32'd0);
        check({tag, "_rx_valid"}, {31'd0, rx_valid_o}, 32'd0);
        check({tag, "_underrun"}, {31'd0, tx_underrun_o}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        logic [7:0] miso;
        logic [7:0] miso2;
        logic       m;
        int         rx_base;
        int         ur_base;

        vecs[0] = '{load: 1'b1, tx: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5, exp_rx: 8'h3C, exp_ur: 0};
        vecs[1] = '{load: 1'b0, tx: 8'h00, mosi: 8'h55, exp_miso: 8'h00, exp_rx: 8'h55, exp_ur: 1};
        vecs[2] = '{load: 1'b1, tx: 8'hFF, mosi: 8'h00, exp_miso: 8'hFF, exp_rx: 8'h00, exp_ur: 0};
        vecs[3] = '{load: 1'b1, tx: 8'h80, mosi: 8'h01, exp_miso: 8'h80, exp_rx: 8'h01, exp_ur: 0};
        vecs[4] = '{load: 1'b0, tx: 8'h00, mosi: 8'hAA, exp_miso: 8'h00, exp_rx: 8'hAA, exp_ur: 1};

        rst_ni   = 1'b0;
        sclk     = 1'b0;
        ss_n     = 1'b1;
        sd       = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_ni = 1'b1;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            rx_base = rx_total;
            ur_base = ur_total;
            if (vecs[v].load) load_tx(vecs[v].tx);
            start_frame();
            spi_word(vecs[v].mosi, 1'b1, miso);
            repeat (10) @(negedge clk);
            check($sformatf("v%0d_miso", v), {24'd0, miso}, {24'd0, vecs[v].exp_miso});
            check($sformatf("v%0d_rx_data", v), {24'd0, rx_data_o}, {24'd0, vecs[v].exp_rx});
            check($sformatf("v%0d_rx_pulses", v), rx_total - rx_base, 1);
            check($sformatf("v%0d_underruns", v), ur_total - ur_base, vecs[v].exp_ur);
            check($sformatf("v%0d_tx_ready", v), {31'd0, tx_ready_o}, 32'd1);
            check($sformatf("v%0d_sd_oe_idle", v), {31'd0, sd_oe}, 32'd0);
        end

        // Back-to-back words in one select window, with sd_oe assertion timing
        rx_base = rx_total;
        ur_base = ur_total;
        load_tx(8'h11);
        ss_n = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b_sd_oe_early", {31'd0, sd_oe}, 32'd0);
        @(negedge clk);
        check("b2b_sd_oe_on", {31'd0, sd_oe}, 32'd1);
        check("b2b_busy_on", {31'd0, busy_o}, 32'd1);
        repeat (5) @(negedge clk);
        load_tx(8'h22);
        spi_word(8'hF0, 1'b0, miso);
        spi_word(8'h0F, 1'b1, miso2);
        repeat (10) @(negedge clk);
        check("b2b_miso0", {24'd0, miso}, 32'h11);
        check("b2b_miso1", {24'd0, miso2}, 32'h22);
        check("b2b_rx_pulses", rx_total - rx_base, 2);
        check("b2b_rx0", {24'd0, rx_log[rx_base % 16]}, 32'hF0);
        check("b2b_rx1", {24'd0, rx_log[(rx_base + 1) % 16]}, 32'h0F);
        check("b2b_underruns", ur_total - ur_base, 0);

        // Abort after 5 bits, then a clean frame
        rx_base = rx_total;
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, i == 4, m);
        repeat (10) @(negedge clk);
        check("abort_rx_pulses", rx_total - rx_base, 0);
        check("abort_sd_oe", {31'd0, sd_oe}, 32'd0);
        check("abort_rx_held", {24'd0, rx_data_o}, 32'h0F);
        start_frame();
        spi_word(8'h81, 1'b1, miso);
        repeat (10) @(negedge clk);
        check("abort_next_rx", {24'd0, rx_data_o}, 32'h81);
        check("abort_next_pulses", rx_total - rx_base, 1);

        // Reset mid-frame with the holding register full
        load_tx(8'h5A);
        start_frame();
        for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, m);
        load_tx(8'h77);
        rst_ni = 1'b0;
        ss_n   = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk);
        rx_base = rx_total;
        ur_base = ur_total;
        load_tx(8'h3C);
        start_frame();
        spi_word(8'hC3, 1'b1, miso);
        repeat (10) @(negedge clk);
        check("post_rst_rx", {24'd0, rx_data_o}, 32'hC3);
        check("post_rst_miso", {24'd0, miso}, 32'h3C);
        check("post_rst_pulses", rx_total - rx_base, 1);
        check("post_rst_underruns", ur_total - ur_base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
